// File: rtl/lif_sched_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron scheduler:
// default geometry, leak-shift width and the sweep FSM state encoding.
package lif_sched_pkg;

  localparam int unsigned DEF_N_NEURONS = 4;
  localparam int unsigned DEF_W         = 8;
  localparam int unsigned LEAK_SHIFT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leak / integrate / threshold for one LIF neuron.
// Ports:
//   v, acc       current membrane value and accumulated synaptic current
//   leak_shift   leak = v >> leak_shift
//   thresh       spike when the integrated value is >= thresh
//   hold         neuron is refractory: force stored value 0, no spike
//   v_next_c     value to store back (0 after a spike)
//   spike_c      neuron fires this update
module lif_update_unit
  import lif_sched_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic [W-1:0]            v,
  input  logic [W-1:0]            acc,
  input  logic [LEAK_SHIFT_W-1:0] leak_shift,
  input  logic [W-1:0]            thresh,
  input  logic                    hold,
  output logic [W-1:0]            v_next_c,
  output logic                    spike_c
);

  logic [W-1:0] leaked;
  logic [W:0]   sum;
  logic [W-1:0] v_int;

  // v - (v >> s) never underflows, so only the add needs saturation
  always_comb begin
    leaked   = v - (v >> leak_shift);
    sum      = {1'b0, leaked} + {1'b0, acc};
    v_int    = sum[W] ? {W{1'b1}} : sum[W-1:0];
    spike_c  = 1'b0;
    v_next_c = '0;
    if (!hold) begin
      spike_c  = (v_int >= thresh);
      v_next_c = spike_c ? '0 : v_int;
    end
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Time-division-multiplexed leaky integrate-and-fire scheduler: N_NEURONS
// virtual neurons share one update unit; a tick starts a sweep that updates
// one neuron per cycle.
// Optional build macro: LIF_SCHED_REFRACTORY_EN adds per-neuron refractory
// counters (REFRACTORY_TICKS sweeps of hold after a spike).
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   tick                      start a sweep (ignored and flagged when busy)
//   in_valid/in_ready         current handshake, ready only in IDLE
//   in_idx, in_current        target neuron and unsigned current
//   thresh, leak_shift        update parameters, sampled every update
//   busy                      sweep or its trailing DONE cycle in progress
//   spike_valid, spike_idx    registered spike event
//   membrane_out, mem_idx     registered post-update stored membrane value
//   overrun                   sticky: tick seen while busy
module lif_tdm_scheduler
  import lif_sched_pkg::*;
#(
  parameter int unsigned N_NEURONS        = DEF_N_NEURONS,
  parameter int unsigned W                = DEF_W,
  parameter int unsigned REFRACTORY_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(N_NEURONS)-1:0] in_idx,
  input  logic [W-1:0]                 in_current,
  input  logic [W-1:0]                 thresh,
  input  logic [LEAK_SHIFT_W-1:0]      leak_shift,
  output logic                         busy,
  output logic                         spike_valid,
  output logic [$clog2(N_NEURONS)-1:0] spike_idx,
  output logic [W-1:0]                 membrane_out,
  output logic [$clog2(N_NEURONS)-1:0] mem_idx,
  output logic                         overrun
);

  localparam int unsigned IDX_W = $clog2(N_NEURONS);

  sched_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]   v_q   [N_NEURONS];
  logic [W-1:0]   acc_q [N_NEURONS];

  logic           busy_d, in_ready_d, overrun_d;
  logic           sweep_en, accept;
  logic [W:0]     acc_sum_c;
  logic [W-1:0]   acc_new_c;
  logic [W-1:0]   upd_v_c;
  logic           upd_spike_c;
  logic           hold_c;

  // FSM state and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= busy_d;
      in_ready <= in_ready_d;
      overrun  <= overrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SWEEP;
      ST_SWEEP: if (idx_q == IDX_W'(N_NEURONS - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / control decode; flags are registered from the next state so
  // they line up with the state they describe
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    in_ready_d = (state_d == ST_IDLE);
    overrun_d  = overrun | (tick & (state_q != ST_IDLE));
    sweep_en   = (state_q == ST_SWEEP);
    accept     = in_ready & in_valid;
  end

  // Saturating accumulate of the incoming current
  always_comb begin
    acc_sum_c = {1'b0, acc_q[in_idx]} + {1'b0, in_current};
    acc_new_c = acc_sum_c[W] ? {W{1'b1}} : acc_sum_c[W-1:0];
  end

  lif_update_unit #(
    .W (W)
  ) u_update (
    .v          (v_q[idx_q]),
    .acc        (acc_q[idx_q]),
    .leak_shift (leak_shift),
    .thresh     (thresh),
    .hold       (hold_c),
    .v_next_c   (upd_v_c),
    .spike_c    (upd_spike_c)
  );

`ifdef LIF_SCHED_REFRACTORY_EN
  localparam int unsigned RC_W = (REFRACTORY_TICKS < 1) ? 1 : $clog2(REFRACTORY_TICKS + 1);

  logic [RC_W-1:0] refr_q [N_NEURONS];

  assign hold_c = (refr_q[idx_q] != '0);

  // Refractory counters: reload on spike, count down once per sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
    end else if (sweep_en) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          if (hold_c) refr_q[i] <= refr_q[i] - RC_W'(1);
          else if (upd_spike_c) refr_q[i] <= RC_W'(REFRACTORY_TICKS);
        end
      end
    end
  end
`else
  assign hold_c = 1'b0;
`endif

  // Neuron state, accumulators, sweep pointer and event outputs.
  // Accepts only happen in IDLE and updates only in SWEEP, so the two
  // writers of acc_q never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]   <= '0;
        acc_q[i] <= '0;
      end
      idx_q        <= '0;
      spike_valid  <= 1'b0;
      spike_idx    <= '0;
      membrane_out <= '0;
      mem_idx      <= '0;
    end else begin
      spike_valid <= sweep_en & upd_spike_c;
      if (sweep_en) begin
        idx_q        <= idx_q + IDX_W'(1);
        membrane_out <= upd_v_c;
        mem_idx      <= idx_q;
        if (upd_spike_c) spike_idx <= idx_q;
      end
      for (int i = 0; i < N_NEURONS; i++) begin
        if (sweep_en && (idx_q == IDX_W'(i))) begin
          v_q[i]   <= upd_v_c;
          acc_q[i] <= '0;
        end else if (accept && (in_idx == IDX_W'(i))) begin
          acc_q[i] <= acc_new_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Bench for lif_tdm_scheduler: directed scenarios plus randomized sweeps
// checked against an array-based behavioural neuron model.
module tb_lif_tdm_scheduler;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int RT   = 2;
  localparam int MAXV = 255;
`ifdef LIF_SCHED_REFRACTORY_EN
  localparam bit REFR_EN = 1'b1;
`else
  localparam bit REFR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_idx;
  logic [W-1:0] in_current;
  logic [W-1:0] thresh;
  logic [2:0]   leak_shift;
  logic         busy;
  logic         spike_valid;
  logic [1:0]   spike_idx;
  logic [W-1:0] membrane_out;
  logic [1:0]   mem_idx;
  logic         overrun;

  lif_tdm_scheduler #(
    .N_NEURONS        (N),
    .W                (W),
    .REFRACTORY_TICKS (RT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_idx       (in_idx),
    .in_current   (in_current),
    .thresh       (thresh),
    .leak_shift   (leak_shift),
    .busy         (busy),
    .spike_valid  (spike_valid),
    .spike_idx    (spike_idx),
    .membrane_out (membrane_out),
    .mem_idx      (mem_idx),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mv    [N];
  int macc  [N];
  int mrefr [N];
  bit movr;
  int th;
  int ls;
  bit dut_spike0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; macc[i] = 0; mrefr[i] = 0;
    end
    movr = 1'b0;
  endtask

  task automatic model_add(input int idx, input int cur);
    macc[idx] = (macc[idx] + cur > MAXV) ? MAXV : macc[idx] + cur;
  endtask

  task automatic set_params(input int t, input int s);
    th = t; ls = s;
    thresh = W'(t); leak_shift = 3'(s);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_spike_valid"}, spike_valid, 0);
    chk({tag, "_spike_idx"}, spike_idx, 0);
    chk({tag, "_membrane"}, membrane_out, 0);
    chk({tag, "_mem_idx"}, mem_idx, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  // One accepted current transfer in IDLE
  task automatic push(input int idx, input int cur);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_idx = 2'(idx); in_current = W'(cur);
    @(posedge clk);
    model_add(idx, cur);
    #1;
    in_valid = 1'b0;
  endtask

  // Full sweep: optional same-cycle input with the tick, optional extra tick
  // during SWEEP cycle extra_at (-1 = none). Checks every per-neuron result.
  task automatic sweep(input bit with_in, input int idx, input int cur, input int extra_at);
    int ev[N];
    bit es[N];
    int vn;
    int busy_cycles;
    @(negedge clk);
    tick = 1'b1;
    if (with_in) begin
      in_valid = 1'b1; in_idx = 2'(idx); in_current = W'(cur);
    end
    @(posedge clk);
    if (with_in) model_add(idx, cur);
    #1;
    tick = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      es[k] = 1'b0;
      if (REFR_EN && mrefr[k] > 0) begin
        mrefr[k]--;
        mv[k] = 0;
      end else begin
        vn = mv[k] - (mv[k] >> ls) + macc[k];
        if (vn > MAXV) vn = MAXV;
        if (vn >= th) begin
          es[k] = 1'b1;
          mv[k] = 0;
          if (REFR_EN) mrefr[k] = RT;
        end else begin
          mv[k] = vn;
        end
      end
      macc[k] = 0;
      ev[k] = mv[k];
    end
    busy_cycles = busy ? 1 : 0;
    chk("in_ready_low_in_sweep", in_ready, 0);
    chk("spike_valid_before_first", spike_valid, 0);
    dut_spike0 = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      tick = (k == extra_at);
      if (k == extra_at) movr = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      if (busy) busy_cycles++;
      chk("spike_valid", spike_valid, es[k]);
      chk("mem_idx", mem_idx, k);
      chk("membrane_out", membrane_out, ev[k]);
      if (es[k]) chk("spike_idx", spike_idx, k);
      if (k == 0) dut_spike0 = spike_valid && (spike_idx == 2'd0);
    end
    @(posedge clk);
    #1;
    chk("busy_cycles", busy_cycles, N + 1);
    chk("busy_after_done", busy, 0);
    chk("in_ready_after_done", in_ready, 1);
    chk("spike_valid_after_done", spike_valid, 0);
    chk("overrun", overrun, movr);
  endtask

  initial begin
    int npush;
    rst_n = 1'b0; tick = 1'b0; in_valid = 1'b0; in_idx = '0; in_current = '0;
    set_params(100, 7);
    model_clear();
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);
    chk("busy_after_reset", busy, 0);

    // Sub-threshold integrate, then crossing threshold
    set_params(100, 7);
    push(1, 60);
    sweep(1'b0, 0, 0, -1);
    push(1, 50);
    sweep(1'b0, 0, 0, -1);

    // Accumulator saturation
    set_params(255, 7);
    push(2, 200);
    push(2, 100);
    sweep(1'b0, 0, 0, -1);

    // Leak: V0=128 then shift-by-1 leak
    push(0, 128);
    sweep(1'b0, 0, 0, -1);
    set_params(255, 1);
    sweep(1'b0, 0, 0, -1);

    // Zero threshold with input in the same cycle as the tick
    set_params(0, 3);
    sweep(1'b1, 3, 77, -1);

    // Tick while busy: overrun, no extra sweep
    set_params(200, 2);
    sweep(1'b0, 0, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    chk("no_extra_sweep_busy", busy, 0);
    chk("overrun_sticky", overrun, 1);

    // Reset in the middle of a sweep
    set_params(255, 7);
    push(0, 90);
    push(3, 40);
    sweep(1'b0, 0, 0, -1);
    @(negedge clk); tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_mid_reset", in_ready, 1);
    chk("busy_after_mid_reset", busy, 0);
    set_params(200, 7);
    sweep(1'b0, 0, 0, -1);

    // Randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      set_params(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)));
      npush = int'($urandom_range(0, 4));
      for (int p = 0; p < npush; p++)
        push(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      sweep(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, N - 1)) : -1);
    end

`ifdef LIF_SCHED_REFRACTORY_EN
    // Refractory: constant drive fires on sweeps 1 and 4 only
    @(negedge clk); rst_n = 1'b0;
    #1; model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_params(10, 7);
    for (int s = 1; s <= 5; s++) begin
      push(0, 20);
      sweep(1'b0, 0, 0, -1);
      chk("refractory_spike_pattern", dut_spike0, (s == 1 || s == 4));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
